// File: rtl/v_lane_issue.sv
// rtl/v_lane_issue.sv - vector lane issue FSM: VRF read, lane execute, VRF writeback.
// Optional EXEC watchdog is compiled in with V_ISSUE_TIMEOUT_EN.
module v_lane_issue (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op_alu,
    input  logic         req_is_mul,
    input  logic [2:0]   req_vsew,
    input  logic [2:0]   req_lmul,
    input  logic [4:0]   req_vd,
    input  logic [4:0]   req_vs1,
    input  logic [4:0]   req_vs2,
    output logic         vrf_rd_en,
    output logic [4:0]   vrf_rd_addr_a,
    output logic [4:0]   vrf_rd_addr_b,
    input  logic [127:0] vrf_rd_data_a,
    input  logic [127:0] vrf_rd_data_b,
    output logic [511:0] lane_op_a,
    output logic [511:0] lane_op_b,
    output logic [3:0]   op_instr_alu,
    output logic         is_mul,
    output logic [2:0]   vsew,
    output logic [2:0]   lmul,
    input  logic         done_valu,
    input  logic         done_vmul,
    input  logic [511:0] result_valu,
    input  logic [511:0] result_vmul,
    output logic         vrf_wr_en,
    output logic [4:0]   vrf_wr_addr,
    output logic [127:0] vrf_wr_data,
    output logic         cmp_valid,
    output logic         err
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [3:0]     op_q;
    logic           mul_q;
    logic [2:0]     vsew_q, lmul_q;
    logic [4:0]     vd_q, vs1_q, vs2_q;
    logic [511:0]   opa_q, opb_q, res_q;

    logic           alu_op, req_illegal, accept, done_hit;
    logic [2:0]     n_grp;
    logic [1:0]     rd_grp;

    assign alu_op      = (req_op_alu >= 4'd1) && (req_op_alu <= 4'd10);
    assign req_illegal = (req_lmul >= 3'd3) || (alu_op && req_is_mul) || (!alu_op && !req_is_mul);
    assign accept      = (state_q == IDLE) && req_valid && !req_illegal;
    assign n_grp       = (lmul_q == 3'd0) ? 3'd1 : (lmul_q == 3'd1) ? 3'd2 : 3'd4;
    assign done_hit    = mul_q ? done_vmul : done_valu;
    // Read data lags the address by one cycle, so READ count k captures group k-1.
    assign rd_grp      = 2'(cnt_q - 3'd1);
    assign lane_op_a   = opa_q;
    assign lane_op_b   = opb_q;

`ifdef V_ISSUE_TIMEOUT_EN
    logic [7:0] tmo_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != EXEC) tmo_q <= 8'd0;
        else                        tmo_q <= tmo_q + 8'd1;
    end
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_ready     = 1'b0;
        vrf_rd_en     = 1'b0;
        vrf_rd_addr_a = 5'd0;
        vrf_rd_addr_b = 5'd0;
        op_instr_alu  = 4'd0;
        is_mul        = 1'b0;
        vsew          = 3'd0;
        lmul          = 3'd0;
        vrf_wr_en     = 1'b0;
        vrf_wr_addr   = 5'd0;
        vrf_wr_data   = 128'd0;
        cmp_valid     = 1'b0;
        err           = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_illegal) begin
                        err = 1'b1;
                    end else begin
                        state_d = READ;
                        cnt_d   = 3'd0;
                    end
                end
            end
            READ: begin
                if (cnt_q < n_grp) begin
                    vrf_rd_en     = 1'b1;
                    vrf_rd_addr_a = vs1_q + {2'b00, cnt_q};
                    vrf_rd_addr_b = vs2_q + {2'b00, cnt_q};
                end
                if (cnt_q == n_grp) begin
                    state_d = EXEC;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            EXEC: begin
                op_instr_alu = mul_q ? 4'd0 : op_q;
                is_mul       = mul_q;
                vsew         = vsew_q;
                lmul         = lmul_q;
                if (done_hit) begin
                    state_d = WB;
`ifdef V_ISSUE_TIMEOUT_EN
                end else if (tmo_q == 8'hff) begin
                    err     = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            WB: begin
                vrf_wr_en   = 1'b1;
                vrf_wr_addr = vd_q + {2'b00, cnt_q};
                vrf_wr_data = res_q[{cnt_q[1:0], 7'd0} +: 128];
                if (cnt_q == n_grp - 3'd1) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                cmp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            op_q    <= 4'd0;
            mul_q   <= 1'b0;
            vsew_q  <= 3'd0;
            lmul_q  <= 3'd0;
            vd_q    <= 5'd0;
            vs1_q   <= 5'd0;
            vs2_q   <= 5'd0;
            opa_q   <= 512'd0;
            opb_q   <= 512'd0;
            res_q   <= 512'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q   <= req_op_alu;
                mul_q  <= req_is_mul;
                vsew_q <= req_vsew;
                lmul_q <= req_lmul;
                vd_q   <= req_vd;
                vs1_q  <= req_vs1;
                vs2_q  <= req_vs2;
                opa_q  <= 512'd0;
                opb_q  <= 512'd0;
            end
            if (state_q == READ && cnt_q != 3'd0) begin
                opa_q[{rd_grp, 7'd0} +: 128] <= vrf_rd_data_a;
                opb_q[{rd_grp, 7'd0} +: 128] <= vrf_rd_data_b;
            end
            if (state_q == EXEC && done_hit)
                res_q <= mul_q ? result_vmul : result_valu;
        end
    end

endmodule

// File: tb/tb_v_lane_issue.sv
// tb/tb_v_lane_issue.sv - randomized bench for v_lane_issue against a cycle-schedule reference model.
module tb_v_lane_issue;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [3:0]   req_op_alu;
    logic         req_is_mul;
    logic [2:0]   req_vsew, req_lmul;
    logic [4:0]   req_vd, req_vs1, req_vs2;
    logic         vrf_rd_en;
    logic [4:0]   vrf_rd_addr_a, vrf_rd_addr_b;
    logic [127:0] vrf_rd_data_a, vrf_rd_data_b;
    logic [511:0] lane_op_a, lane_op_b;
    logic [3:0]   op_instr_alu;
    logic         is_mul;
    logic [2:0]   vsew, lmul;
    logic         done_valu, done_vmul;
    logic [511:0] result_valu, result_vmul;
    logic         vrf_wr_en;
    logic [4:0]   vrf_wr_addr;
    logic [127:0] vrf_wr_data;
    logic         cmp_valid, err;

    int checks = 0;
    int errors = 0;
    logic [127:0] mem [32];
    logic [511:0] res;

    always #5 clk = ~clk;

    v_lane_issue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op_alu(req_op_alu),
        .req_is_mul(req_is_mul), .req_vsew(req_vsew), .req_lmul(req_lmul),
        .req_vd(req_vd), .req_vs1(req_vs1), .req_vs2(req_vs2),
        .vrf_rd_en(vrf_rd_en), .vrf_rd_addr_a(vrf_rd_addr_a), .vrf_rd_addr_b(vrf_rd_addr_b),
        .vrf_rd_data_a(vrf_rd_data_a), .vrf_rd_data_b(vrf_rd_data_b),
        .lane_op_a(lane_op_a), .lane_op_b(lane_op_b), .op_instr_alu(op_instr_alu),
        .is_mul(is_mul), .vsew(vsew), .lmul(lmul),
        .done_valu(done_valu), .done_vmul(done_vmul),
        .result_valu(result_valu), .result_vmul(result_vmul),
        .vrf_wr_en(vrf_wr_en), .vrf_wr_addr(vrf_wr_addr), .vrf_wr_data(vrf_wr_data),
        .cmp_valid(cmp_valid), .err(err)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] obs_vec();
        return 512'({vrf_rd_en, vrf_rd_addr_a, vrf_rd_addr_b, vrf_wr_en, vrf_wr_addr, vrf_wr_data,
                     cmp_valid, err, req_ready, op_instr_alu, is_mul, vsew, lmul});
    endfunction

    function automatic logic [511:0] mk_vec(input bit rd, input logic [4:0] ra, input logic [4:0] rb,
                                            input bit wr, input logic [4:0] wa, input logic [127:0] wd,
                                            input bit cmp, input bit e, input bit rdy, input logic [3:0] op,
                                            input bit m, input logic [2:0] sew, input logic [2:0] lm);
        return 512'({rd, ra, rb, wr, wa, wd, cmp, e, rdy, op, m, sew, lm});
    endfunction

    task automatic drive_req(input logic [3:0] op, input bit mul, input logic [2:0] sew, input logic [2:0] lm,
                             input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
        req_valid = 1'b1; req_op_alu = op; req_is_mul = mul; req_vsew = sew;
        req_lmul = lm; req_vd = vd; req_vs1 = vs1; req_vs2 = vs2;
    endtask

    // One request from acceptance to completion; the expected output of every cycle is
    // derived from the schedule: accept, N+1 read, d exec, N writeback, 1 done.
    task automatic do_op(input logic [3:0] op, input bit mul, input logic [2:0] sew, input logic [2:0] lm,
                         input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                         input int d, input bit b2b, input bit rst_wb);
        int n, exec_end, wbs, t_end, k;
        bit tmo, aborted, rd, inx, wr, cmp, e;
        logic [511:0] ea, eb;
        logic [127:0] wd;
        n = 1 << lm;
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        res = rand512();
        tmo = 1'b0;
`ifdef V_ISSUE_TIMEOUT_EN
        tmo = (d > 256);
`endif
        exec_end = tmo ? n + 1 + 256 : n + 1 + d;
        wbs      = exec_end + 1;
        t_end    = tmo ? exec_end : (rst_wb ? wbs + 1 : wbs + n);
        ea = '0; eb = '0;
        for (int g = 0; g < n; g++) begin
            ea[128*g +: 128] = mem[5'(vs1 + g)];
            eb[128*g +: 128] = mem[5'(vs2 + g)];
        end
        drive_req(op, mul, sew, lm, vd, vs1, vs2);
        #1;
        check("accept", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int t = 1; t <= t_end; t++) begin
            @(negedge clk);
            aborted = rst_wb && (t >= wbs + 1);
            rd  = !aborted && t >= 1 && t <= n;
            inx = !aborted && t >= n + 2 && t <= exec_end;
            wr  = !aborted && !tmo && t >= wbs && t <= wbs + n - 1;
            k   = t - wbs;
            wd  = wr ? res[128*k +: 128] : 128'd0;
            cmp = !aborted && !tmo && t == wbs + n;
            e   = tmo && t == exec_end;
            check($sformatf("cyc%0d", t), obs_vec(),
                  mk_vec(rd, rd ? 5'(vs1 + t - 1) : 5'd0, rd ? 5'(vs2 + t - 1) : 5'd0,
                         wr, wr ? 5'(vd + k) : 5'd0, wd, cmp, e, aborted,
                         (inx && !mul) ? op : 4'd0, inx && mul, inx ? sew : 3'd0, inx ? lm : 3'd0));
            if (t == n + 2) begin
                check("lane_op_a", lane_op_a, ea);
                check("lane_op_b", lane_op_b, eb);
            end
            if (rst_wb && t == wbs + 1) begin
                check("rst_op_a", lane_op_a, 512'd0);
                rst = 1'b0;
            end
            if (b2b)
                drive_req(4'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                          5'($urandom), 5'($urandom), 5'($urandom));
            else
                req_valid = 1'b0;
            if (t >= 2 && t <= n + 1) begin
                vrf_rd_data_a = mem[5'(vs1 + t - 2)];
                vrf_rd_data_b = mem[5'(vs2 + t - 2)];
            end else begin
                vrf_rd_data_a = {$urandom, $urandom, $urandom, $urandom};
                vrf_rd_data_b = {$urandom, $urandom, $urandom, $urandom};
            end
            done_valu = 1'b0; done_vmul = 1'b0;
            result_valu = rand512(); result_vmul = rand512();
            if (!tmo && t == exec_end) begin
                if (mul) begin done_vmul = 1'b1; result_vmul = res; end
                else     begin done_valu = 1'b1; result_valu = res; end
            end
            if (inx && (t == n + 2 || t == exec_end)) begin
                if (mul) done_valu = 1'b1;
                else     done_vmul = 1'b1;
            end
            if (rst_wb && t == wbs) rst = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b0; done_valu = 1'b0; done_vmul = 1'b0;
    endtask

    task automatic do_illegal(input logic [3:0] op, input bit mul, input logic [2:0] lm);
        drive_req(op, mul, 3'($urandom), lm, 5'($urandom), 5'($urandom), 5'($urandom));
        #1;
        check("illegal_err", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("illegal_idle", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(negedge clk);
        check("illegal_noread", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bit mul;
        logic [3:0] op;
        rst = 1'b1; req_valid = 1'b0; req_op_alu = 0; req_is_mul = 0; req_vsew = 0; req_lmul = 0;
        req_vd = 0; req_vs1 = 0; req_vs2 = 0; vrf_rd_data_a = 0; vrf_rd_data_b = 0;
        done_valu = 0; done_vmul = 0; result_valu = 0; result_vmul = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_vec", obs_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        check("reset_op_a", lane_op_a, 512'd0);
        check("reset_op_b", lane_op_b, 512'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'd1, 1'b0, 3'd2, 3'd0, 5'd4, 5'd2, 5'd3, 3, 1'b0, 1'b0);
        do_op(4'd0, 1'b1, 3'd1, 3'd2, 5'd30, 5'd30, 5'd17, 2, 1'b0, 1'b0);
        do_illegal(4'd3, 1'b1, 3'd0);
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: do_illegal(4'(1 + $urandom % 10), 1'b0, 3'(3 + $urandom % 5));
                1: do_illegal(4'(1 + $urandom % 10), 1'b1, 3'($urandom % 3));
                default: do_illegal(($urandom % 2) ? 4'd0 : 4'(11 + $urandom % 5), 1'b0, 3'($urandom % 3));
            endcase
        end
        for (int i = 0; i < 16; i++) begin
            mul = 1'($urandom);
            op  = mul ? (($urandom % 2) ? 4'd0 : 4'(11 + $urandom % 5)) : 4'(1 + $urandom % 10);
            do_op(op, mul, 3'($urandom), 3'($urandom % 3), 5'($urandom), 5'($urandom),
                  5'($urandom), 1 + $urandom % 6, 1'($urandom), 1'b0);
        end
        do_op(4'd5, 1'b0, 3'd0, 3'd2, 5'd29, 5'd1, 5'd2, 2, 1'b0, 1'b1);
        do_op(4'd0, 1'b1, 3'd3, 3'd1, 5'd8, 5'd9, 5'd10, 256, 1'b0, 1'b0);
        do_op(4'd7, 1'b0, 3'd2, 3'd0, 5'd11, 5'd12, 5'd13, 300, 1'b0, 1'b0);
        do_op(4'd2, 1'b0, 3'd1, 3'd1, 5'd31, 5'd31, 5'd0, 1, 1'b1, 1'b0);
        do_op(4'd9, 1'b0, 3'd1, 3'd0, 5'd3, 5'd4, 5'd5, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/v_lane_issue.md
V_LANE_ISSUE -- requirements
Module: v_lane_issue

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: req_valid in 1; req_ready out 1; req_op_alu in 4, ALU opcode, 0=none; req_is_mul in 1; req_vsew in 3; req_lmul in 3; req_vd/req_vs1/req_vs2 in 5 each.
REQ-003 SHALL have VRF read ports: vrf_rd_en out 1; vrf_rd_addr_a/vrf_rd_addr_b out 5; vrf_rd_data_a/vrf_rd_data_b in 128, valid one cycle after vrf_rd_en.
REQ-004 SHALL have lane ports: lane_op_a/lane_op_b out 512, register group k in bits [128k+127:128k]; op_instr_alu out 4; is_mul out 1; vsew out 3; lmul out 3; done_valu/done_vmul in 1; result_valu/result_vmul in 512.
REQ-005 SHALL have writeback/status ports: vrf_wr_en out 1; vrf_wr_addr out 5; vrf_wr_data out 128; cmp_valid out 1; err out 1.

Function
REQ-006 SHALL set group count N=1/2/4 for req_lmul=0/1/2; req_lmul>=3 is illegal.
REQ-007 SHALL use FSM states IDLE, READ, EXEC, WB, DONE; req_ready=1 only in IDLE.
REQ-008 SHALL accept a request on req_valid&&req_ready, latch all req_* fields, then go to READ; an illegal request is not latched, raises err for one cycle and FSM stays IDLE.
REQ-009 SHALL treat a request as illegal when lmul>=3, both req_op_alu in 1..10 and req_is_mul=1, or neither holds.
REQ-010 READ: SHALL issue N consecutive vrf_rd_en cycles with addresses vs1+k, vs2+k (k=0..N-1, mod 32), capture each returned pair into group k, and enter EXEC the cycle after the last capture (N+1 cycles in READ).
REQ-011 EXEC: SHALL drive op_instr_alu=latched opcode (ALU op) or is_mul=1 (MUL op), latched vsew/lmul, and hold lane_op_a/b stable until done.
REQ-012 SHALL use only the done input matching the op type (done_valu for ALU, done_vmul for MUL); the other is ignored even when asserted simultaneously.
REQ-013 SHALL capture the matching 512-bit result on the done cycle and enter WB next cycle.
REQ-014 Outside EXEC, op_instr_alu SHALL be 0 and is_mul 0, so lane done flags clear before the next op.
REQ-015 WB: SHALL write N groups, one per cycle, vrf_wr_addr=vd+k (mod 32), vrf_wr_data=result group k, k ascending.
REQ-016 DONE: SHALL pulse cmp_valid for exactly one cycle, then return to IDLE.
REQ-017 Unused groups (k>=N) of lane_op_a/b SHALL be driven 0.
REQ-018 req_valid while not ready SHALL be ignored without side effect.

Reset
REQ-019 On rst, FSM SHALL enter IDLE and all outputs SHALL be 0 except req_ready=1, in the cycle after rst sampled high.
REQ-020 rst mid-operation SHALL abort without any further VRF write or cmp_valid.

Configuration
REQ-021 With V_ISSUE_TIMEOUT_EN defined, an 8-bit counter SHALL count EXEC cycles; the 256th cycle without matching done SHALL abort to IDLE, pulse err one cycle, no WB, no cmp_valid.
REQ-022 Without V_ISSUE_TIMEOUT_EN, EXEC SHALL wait indefinitely and no counter shall exist.

Verification
REQ-023 ALU add, lmul=0, vs1=2, vs2=3, vd=4, done_valu 3 cycles into EXEC -> one write to v4, cmp_valid once, total latency 1+2+3+1+1 cycles.
REQ-024 MUL, lmul=2, vs1=30 -> read addresses 30,31,0,1; writes to vd..vd+3 with wrap; done_valu asserted alone ignored.
REQ-025 req_op_alu=3 with req_is_mul=1 -> err pulse, req_ready stays 1, no vrf_rd_en.
REQ-026 rst asserted during WB after first write -> no further vrf_wr_en, cmp_valid never asserts, req_ready=1 after reset.
REQ-027 With V_ISSUE_TIMEOUT_EN, done never asserted -> err at EXEC cycle 256, IDLE next; without the macro, FSM remains in EXEC.
REQ-028 Back-to-back requests with req_valid held high -> second accepted only in the cycle after cmp_valid; op_instr_alu is 0 for at least one cycle between ops.
